uart_rx_deframer: RTL
=====================

# uart_rx_deframer

Receive-side framing stage of the UART, directly downstream of the oversampling bit sampler. It consumes the sampler's majority-voted bit stream (`out`/`valid`), checks the start bit, assembles LSB-first data bits, checks optional parity and the stop bit(s), and presents the byte through a one-entry holding register with a valid/ready handshake. At the end of every frame, and on a false start, it pulses the sampler's `stop` input so the sampler returns to start-bit hunting.

## Interface
- `DATA_WIDTH`, 8: data bits per frame (5..9).
- `PARITY_EN`, 1: 1 = one parity bit follows the data bits.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity; ignored when `PARITY_EN`=0.
- `STOP_BITS`, 1: number of stop bits checked (1 or 2).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `bit_in`  in  1  sampled bit; connect to sampler `out`.
- `bit_valid`  in  1  one-cycle strobe per sampled bit; connect to sampler `valid`.
- `sampler_stop`  out  1  one-cycle pulse; connect to sampler `stop`.
- `data_out`  out  DATA_WIDTH  received byte; stable while `data_valid`=1.
- `data_valid`  out  1  holding register full.
- `data_ready`  in  1  consumer accepts `data_out` when `data_valid`&&`data_ready`.
- `parity_err`  out  1  parity mismatch for the held byte.
- `frame_err`  out  1  a checked stop bit was 0 for the held byte.
- `overrun_err`  out  1  held byte overwrote an unaccepted byte.
- `busy`  out  1  frame in progress (state not IDLE).

## Operation
- States: IDLE, DATA, PARITY, STOP, RELEASE. Only `bit_valid` strobes advance IDLE/DATA/PARITY/STOP; RELEASE lasts exactly one cycle.
- IDLE: first strobe is the start bit. `bit_in`=0 -> DATA, clear shift register and bit counter. `bit_in`=1 -> false start: RELEASE, no byte, no error flags.
- DATA: each strobe shifts `bit_in` in at the MSB side (LSB-first line order; after DATA_WIDTH strobes bit 0 holds the first data bit). Counter width ceil(log2(DATA_WIDTH+1)); after strobe DATA_WIDTH -> PARITY if `PARITY_EN`, else STOP.
- PARITY: one strobe; computed error = (XOR of data bits XOR `bit_in`) != `PARITY_ODD`. -> STOP.
- STOP: STOP_BITS strobes; any 0 sets the frame error. After the last stop strobe -> RELEASE and commit the frame.
- Commit (same edge as the transition into RELEASE): `data_out`<=assembled byte, `parity_err`/`frame_err` <= this frame's results, `data_valid`<=1, `overrun_err`<=1 if `data_valid` was 1 and not accepted that cycle, else 0. A frame with errors is still committed.
- RELEASE: `sampler_stop`=1 for this one cycle; next state IDLE. `bit_valid` in this cycle is ignored.
- Handshake: `data_valid`&&`data_ready` at an edge clears `data_valid`; error flags hold their value until the next commit. Accept and commit on the same edge: no overrun, `data_valid` stays 1 with new data.
- No byte is lost silently: overwrite always raises `overrun_err`.

## Timing
- Reset (rst=0, asynchronous): state IDLE; `data_out`=0, `data_valid`=0, `parity_err`=0, `frame_err`=0, `overrun_err`=0, `sampler_stop`=0, `busy`=0; counters and shift register 0. Reset mid-frame discards the partial frame.
- All outputs registered; no combinational path from inputs to outputs.
- Latency: `data_valid` and `sampler_stop` rise on the edge after the clock in which the last stop-bit `bit_valid` is high; `sampler_stop` falls one cycle later.
- False start: `sampler_stop` high in the cycle after the start strobe.
- `busy` is 1 in DATA, PARITY, STOP and RELEASE.
- `bit_valid` held high for consecutive cycles: each cycle counts as one bit.

## Test plan
- Defaults; frame 0,1,0,1,0,0,1,0,1,0,1 (start, 0xA5 LSB-first, even parity 0, stop) -> `data_out`=0xA5, `data_valid`=1, all errors 0, one `sampler_stop` pulse one cycle after stop strobe.
- Same frame with parity bit 1 -> `data_out`=0xA5, `parity_err`=1; `frame_err`=0.
- Start strobe with `bit_in`=1 -> `sampler_stop` pulse next cycle, `data_valid` stays 0, state back to IDLE.
- Two frames 0x3C then 0xC3, `data_ready`=0 throughout -> `data_out`=0xC3, `overrun_err`=1; raise `data_ready` one cycle -> `data_valid`=0.
- STOP_BITS=2, PARITY_EN=0, 0x55 with second stop bit 0 -> `frame_err`=1, `data_out`=0x55; `sampler_stop` only after second stop strobe.
- Assert rst low after 4 data strobes -> all outputs 0 immediately; next clean frame 0x81 received correctly.

Source files
------------

// File: rtl/uart_rx_deframer.sv
// UART receive framing stage: checks start/parity/stop bits on the sampler's
// voted bit stream and hands the assembled byte out through a one-entry holding register.
module uart_rx_deframer #(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bit_in,
    input  logic                  bit_valid,
    output logic                  sampler_stop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun_err,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        RELEASE
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  stop_cnt;
    logic                  par_bad;
    logic                  frame_bad;
    logic                  start_frame;
    logic                  commit;
    logic                  last_data;
    logic                  last_stop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        commit      = 1'b0;
        last_data   = (bit_cnt == CNT_W'(DATA_WIDTH - 1));
        last_stop   = (STOP_BITS == 1) || stop_cnt;
        case (state)
            IDLE: begin
                if (bit_valid) begin
                    if (!bit_in) begin
                        state_next  = DATA;
                        start_frame = 1'b1;
                    end else begin
                        state_next = RELEASE;
                    end
                end
            end
            DATA: begin
                if (bit_valid && last_data) begin
                    state_next = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_valid) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_valid && last_stop) begin
                    state_next = RELEASE;
                    commit     = 1'b1;
                end
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Frame assembly; error bits of the frame in flight are kept apart from the held flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            par_bad   <= 1'b0;
            frame_bad <= 1'b0;
        end else begin
            if (start_frame) begin
                shift_reg <= '0;
                bit_cnt   <= '0;
                stop_cnt  <= 1'b0;
                par_bad   <= 1'b0;
                frame_bad <= 1'b0;
            end
            if (state == DATA && bit_valid) begin
                shift_reg <= {bit_in, shift_reg[DATA_WIDTH-1:1]};
                bit_cnt   <= bit_cnt + 1'b1;
            end
            if (state == PARITY && bit_valid) begin
                par_bad <= (^shift_reg) ^ bit_in ^ PARITY_ODD[0];
            end
            if (state == STOP && bit_valid) begin
                stop_cnt <= 1'b1;
                if (!bit_in) begin
                    frame_bad <= 1'b1;
                end
            end
        end
    end

    // Holding register: a commit always wins over an accept on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out     <= '0;
            data_valid   <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
            overrun_err  <= 1'b0;
            sampler_stop <= 1'b0;
            busy         <= 1'b0;
        end else begin
            sampler_stop <= (state_next == RELEASE);
            busy         <= (state_next != IDLE);
            if (commit) begin
                data_out    <= shift_reg;
                parity_err  <= par_bad;
                frame_err   <= frame_bad | ~bit_in;
                data_valid  <= 1'b1;
                overrun_err <= data_valid & ~data_ready;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule
